// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver.
//   uart_state_t : frame state shared by uart_tx and uart_rx
//   PAR_*        : parity-mode encodings for the PARITY parameter
//   parity_bit() : parity bit for a byte under a given mode
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Odd parity makes the total count of ones (data + parity) odd.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake into the UART transmitter.
//   i_data  : byte to transmit, sampled when i_valid && o_ready
//   i_valid : producer has a byte
//   o_ready : transmitter holding register is empty
interface uart_tx_if;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;

    modport master (output i_data, output i_valid, input o_ready);
    modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Serial bit timer: counts clk cycles within one bit period.
//   clk, rst_n : clock and async active-low reset
//   clear      : hold the count at zero (used while the line is idle)
//   tick       : high on the last cycle of each bit period
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. A one-entry holding register accepts the next byte
// while the current frame shifts, so streamed frames have no idle gap.
//   clk, rst_n : clock and async active-low reset
//   bus        : byte handshake (i_data, i_valid in; o_ready out)
//   serial     : registered line output, idle high
//   o_busy     : a frame is in progress
//   o_done     : one-cycle pulse after the last stop bit of each frame
//
// state     | meaning
// ----------+---------------------------------------------
// ST_IDLE   | line high, waiting for the holding register
// ST_START  | start bit (line low)
// ST_DATA   | data bit idx, line = shift[0]
// ST_PARITY | parity bit (only when PARITY != PAR_NONE)
// ST_STOP   | stop bit stop_cnt (line high)
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 3,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave bus,
    output logic     serial,
    output logic     o_busy,
    output logic     o_done
);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    uart_state_t state, state_nxt;
    logic [7:0]  hold_data;
    logic        hold_full;
    logic [7:0]  shift, shift_nxt;
    logic        par_bit, par_nxt;
    logic [2:0]  idx, idx_nxt;
    logic        stop_cnt, stop_nxt;
    logic        serial_nxt, done_nxt;
    logic        accept, load, tick, bit_clear;

    // The timer only runs inside a frame, so every START begins at count 0.
    assign bit_clear = (state == ST_IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(bit_clear),
        .tick (tick)
    );

    assign bus.o_ready = ~hold_full;
    assign accept      = bus.i_valid & ~hold_full;
    assign o_busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_data <= bus.i_data;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shift    <= '0;
            par_bit  <= 1'b0;
            idx      <= '0;
            stop_cnt <= 1'b0;
            serial   <= 1'b1;
            o_done   <= 1'b0;
        end else begin
            state    <= state_nxt;
            shift    <= shift_nxt;
            par_bit  <= par_nxt;
            idx      <= idx_nxt;
            stop_cnt <= stop_nxt;
            serial   <= serial_nxt;
            o_done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shift_nxt  = shift;
        par_nxt    = par_bit;
        idx_nxt    = idx;
        stop_nxt   = stop_cnt;
        load       = 1'b0;
        done_nxt   = 1'b0;
        serial_nxt = 1'b1;

        case (state)
            ST_IDLE: begin
                if (hold_full) begin
                    load      = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_nxt = ST_DATA;
                    idx_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_nxt = {1'b0, shift[7:1]};
                    idx_nxt   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_nxt = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                        stop_nxt  = 1'b0;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_nxt = ST_STOP;
                    stop_nxt  = 1'b0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_cnt == STOP_LAST) begin
                        done_nxt = 1'b1;
                        // A waiting byte goes straight into its start bit.
                        if (hold_full) begin
                            load      = 1'b1;
                            state_nxt = ST_START;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        stop_nxt = stop_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (load) begin
            shift_nxt = hold_data;
            par_nxt   = parity_bit(hold_data, PARITY);
        end

        // serial is registered, so it follows the state being entered.
        case (state_nxt)
            ST_START:  serial_nxt = 1'b0;
            ST_DATA:   serial_nxt = shift_nxt[0];
            ST_PARITY: serial_nxt = par_nxt;
            default:   serial_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;
    import uart_pkg::*;

    localparam int NCFG = 4;

    function automatic int cfg_cpb(input int g);
        return (g == 3) ? 2 : 3;
    endfunction
    function automatic int cfg_par(input int g);
        return (g == 1) ? PAR_EVEN : (g == 3) ? PAR_ODD : PAR_NONE;
    endfunction
    function automatic int cfg_stop(input int g);
        return (g >= 2) ? 2 : 1;
    endfunction
    function automatic int frame_len(input int g);
        return (1 + 8 + ((cfg_par(g) != PAR_NONE) ? 1 : 0) + cfg_stop(g)) * cfg_cpb(g);
    endfunction
    // Expected line level for bit slot b of a frame carrying byte d.
    function automatic logic exp_bit(input int g, input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[3'(b - 1)];
        if (cfg_par(g) != PAR_NONE && b == 9)
            return (cfg_par(g) == PAR_EVEN) ? ^d : ~^d;
        return 1'b1;
    endfunction

    typedef struct {
        int         cfg;
        logic [7:0] data;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NCFG-1:0] ser, busy, done, rdy;
    logic [NCFG-1:0] drv_valid;
    logic [7:0]      drv_data [NCFG];

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
        uart_tx_if bus ();
        assign bus.i_data  = drv_data[gi];
        assign bus.i_valid = drv_valid[gi];
        assign rdy[gi]     = bus.o_ready;

        uart_tx #(
            .CLKS_PER_BIT(cfg_cpb(gi)),
            .PARITY      (cfg_par(gi)),
            .STOP_BITS   (cfg_stop(gi))
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus),
            .serial(ser[gi]),
            .o_busy(busy[gi]),
            .o_done(done[gi])
        );
    end

    exp_t q[$];
    int   exp_done [NCFG] = '{default: 0};
    int   n_timeout = 0;
    bit   end_req = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic send(input int g, input logic [7:0] d, input bit push,
                        input bit counts, output int acc);
        int n;
        acc = -1;
        n   = 0;
        @(negedge clk);
        drv_data[g]  = d;
        drv_valid[g] = 1'b1;
        while (rdy[g] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (rdy[g] === 1'b1) begin
            @(posedge clk);
            #1;
            acc = cyc;
            if (push) q.push_back('{cfg: g, data: d, acc: cyc});
            if (counts) exp_done[g]++;
        end else begin
            n_timeout++;
        end
        drv_valid[g] = 1'b0;
        drv_data[g]  = 8'($urandom);
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        while ((busy[g] !== 1'b0 || rdy[g] !== 1'b1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) n_timeout++;
        repeat (3) @(negedge clk);
    endtask

    task automatic stream(input int g, input int count);
        int a;
        for (int i = 0; i < count; i++) begin
            if ($urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 2 * frame_len(g))) @(negedge clk);
            send(g, 8'($urandom), 1'b1, 1'b1, a);
        end
    endtask

    // Stimulus
    initial begin
        int a1, a2;
        drv_valid = '0;
        for (int g = 0; g < NCFG; g++) drv_data[g] = 8'h00;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        send(0, 8'hBB, 1'b1, 1'b1, a1);
        wait_idle(0);
        send(0, 8'h55, 1'b1, 1'b1, a1);
        send(0, 8'hA0, 1'b1, 1'b1, a2);
        wait_idle(0);

        // Reset during data bit 4 with a second byte pending.
        send(0, 8'h3C, 1'b1, 1'b0, a1);
        send(0, 8'hE7, 1'b0, 1'b0, a2);
        while (cyc < a1 + 17) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (60) @(negedge clk);

        stream(0, 16);
        wait_idle(0);

        send(1, 8'hBB, 1'b1, 1'b1, a1);
        wait_idle(1);
        stream(1, 12);
        wait_idle(1);

        send(2, 8'h00, 1'b1, 1'b1, a1);
        wait_idle(2);
        stream(2, 12);
        wait_idle(2);

        send(3, 8'hBB, 1'b1, 1'b1, a1);
        wait_idle(3);
        stream(3, 12);
        wait_idle(3);

        end_req = 1'b1;
    end

    // Monitor / scoreboard
    bit         in_frame [NCFG] = '{default: 1'b0};
    bit         bogus    [NCFG] = '{default: 1'b0};
    bit         ferr     [NCFG] = '{default: 1'b0};
    int         pos      [NCFG] = '{default: 0};
    int         last_end [NCFG] = '{default: 0};
    int         act_done [NCFG] = '{default: 0};
    logic [7:0] cur      [NCFG];
    int         err_pos  [NCFG];
    string      err_sig  [NCFG];
    logic       err_act  [NCFG];
    logic       err_exp  [NCFG];

    task automatic note_err(input int g, input string s, input logic a, input logic e);
        if (!ferr[g]) begin
            ferr[g]    = 1'b1;
            err_pos[g] = pos[g];
            err_sig[g] = s;
            err_act[g] = a;
            err_exp[g] = e;
        end
    endtask

    initial begin
        exp_t e;
        int   exp_start;
        logic eb;
        forever begin
            @(negedge clk);
            if (cyc > 60000) begin
                n_tests++;
                n_fail++;
                $display("FAIL watchdog: cycle %0d reached, required end before 60000", cyc);
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
            for (int g = 0; g < NCFG; g++) begin
                if (!rst_n) begin
                    n_tests++;
                    if (ser[g] !== 1'b1 || rdy[g] !== 1'b1 || busy[g] !== 1'b0 || done[g] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL reset_values cfg%0d: serial=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                                 g, ser[g], rdy[g], busy[g], done[g]);
                    end
                    in_frame[g] = 1'b0;
                    bogus[g]    = 1'b0;
                    last_end[g] = 0;
                end else begin
                    if (done[g] === 1'b1) act_done[g]++;
                    if (in_frame[g] && pos[g] == frame_len(g)) begin
                        if (!bogus[g]) begin
                            n_tests++;
                            if (ferr[g]) begin
                                n_fail++;
                                $display("FAIL frame cfg%0d byte %h: cycle %0d %s=%b, required %b",
                                         g, cur[g], err_pos[g], err_sig[g], err_act[g], err_exp[g]);
                            end
                            n_tests++;
                            if (done[g] !== 1'b1 || busy[g] !== ~ser[g]) begin
                                n_fail++;
                                $display("FAIL frame_end cfg%0d byte %h: done=%b busy=%b serial=%b, required done=1 busy=~serial",
                                         g, cur[g], done[g], busy[g], ser[g]);
                            end
                        end
                        in_frame[g] = 1'b0;
                        last_end[g] = cyc;
                    end
                    if (!in_frame[g] && ser[g] === 1'b0) begin
                        if (q.size() == 0 || q[0].cfg != g) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_frame cfg%0d: start bit at cycle %0d, required no frame", g, cyc);
                            bogus[g] = 1'b1;
                        end else begin
                            e         = q.pop_front();
                            cur[g]    = e.data;
                            bogus[g]  = 1'b0;
                            exp_start = (e.acc + 1 > last_end[g]) ? e.acc + 1 : last_end[g];
                            n_tests++;
                            if (cyc != exp_start) begin
                                n_fail++;
                                $display("FAIL start_time cfg%0d byte %h: start at cycle %0d, required %0d",
                                         g, e.data, cyc, exp_start);
                            end
                        end
                        in_frame[g] = 1'b1;
                        pos[g]      = 0;
                        ferr[g]     = 1'b0;
                    end
                    if (in_frame[g]) begin
                        if (!bogus[g]) begin
                            eb = exp_bit(g, cur[g], pos[g] / cfg_cpb(g));
                            if (ser[g] !== eb) note_err(g, "serial", ser[g], eb);
                            if (busy[g] !== 1'b1) note_err(g, "busy", busy[g], 1'b1);
                            if (pos[g] > 0 && done[g] !== 1'b0) note_err(g, "done", done[g], 1'b0);
                        end
                        pos[g]++;
                    end
                end
            end
            if (end_req) begin
                for (int g = 0; g < NCFG; g++) begin
                    n_tests++;
                    if (act_done[g] != exp_done[g]) begin
                        n_fail++;
                        $display("FAIL done_count cfg%0d: %0d pulses, required %0d", g, act_done[g], exp_done[g]);
                    end
                end
                n_tests++;
                if (q.size() != 0) begin
                    n_fail++;
                    $display("FAIL unsent_bytes: %0d bytes never framed, required 0", q.size());
                end
                n_tests++;
                if (n_timeout != 0) begin
                    n_fail++;
                    $display("FAIL handshake_timeout: %0d waits expired, required 0", n_timeout);
                end
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
        end
    end

endmodule
